// File: rtl/chunk_fifo_if.sv
// Chunk stream bundle: write side (val..data/ready) and FWFT read side (o_*).
// The FIFO takes the slave view; an upstream/downstream agent takes the master view.
interface chunk_fifo_if #(
   parameter int DW = 256
) ();
   logic          val;
   logic          sop;
   logic          eop;
   logic [5:0]    vbc;
   logic [DW-1:0] data;
   logic          ready;

   logic          o_val;
   logic          o_sop;
   logic          o_eop;
   logic [5:0]    o_vbc;
   logic [DW-1:0] o_data;
   logic          o_ready;

   modport slave (
      input  val, sop, eop, vbc, data, o_ready,
      output ready, o_val, o_sop, o_eop, o_vbc, o_data
   );

   modport master (
      output val, sop, eop, vbc, data, o_ready,
      input  ready, o_val, o_sop, o_eop, o_vbc, o_data
   );
endinterface

// File: rtl/chunk_fifo.sv
// First-word-fall-through chunk FIFO with packet framing check on the write side.
// Badly framed or badly sized chunks are dropped and flagged with a one-cycle err pulse.
module chunk_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 256
) (
   input  logic        clk,
   input  logic        reset,
   chunk_fifo_if.slave bus,
   output logic        idle,
   output logic        err,
   output logic [15:0] pkt_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic {S_IDLE, S_IN_PKT} state_t;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [5:0]    vbc;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head;
   entry_t        wr_entry;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   state_t        state_q, state_d;
   logic          err_q, err_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
   logic          ready, not_empty;
   logic          accept, bad_vbc, bad_frame, push, pop;

   // Everything observable downstream depends on registered state only.
   assign ready     = (count_q < FULL_CNT);
   assign not_empty = (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

   assign bus.ready  = ready;
   assign bus.o_val  = not_empty;
   assign bus.o_sop  = head.sop & not_empty;
   assign bus.o_eop  = head.eop & not_empty;
   assign bus.o_vbc  = head.vbc & {6{not_empty}};
   assign bus.o_data = head.data & {DW{not_empty}};

   assign idle    = ~not_empty & (state_q == S_IDLE);
   assign err     = err_q;
   assign pkt_cnt = pkt_cnt_q;

   always_comb begin
      accept    = bus.val & ready;
      bad_vbc   = (bus.vbc == 6'd0) | (bus.vbc > 6'd32) | ((bus.vbc < 6'd32) & ~bus.eop);
      bad_frame = (state_q == S_IDLE) ? ~bus.sop : bus.sop;
      push      = accept & ~bad_vbc & ~bad_frame;
      pop       = not_empty & bus.o_ready;

      wr_entry.sop  = bus.sop;
      wr_entry.eop  = bus.eop;
      wr_entry.vbc  = bus.vbc;
      wr_entry.data = bus.data;
   end

   // Framing FSM advances only on accepted writes; any error drops back to IDLE.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      if (accept) begin
         if (bad_vbc | bad_frame) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
         end else begin
            state_d = bus.eop ? S_IDLE : S_IN_PKT;
         end
      end
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q + AW'(push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
      pkt_cnt_d = pkt_cnt_q;
      if (pop && head.eop && (pkt_cnt_q != 16'hFFFF)) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= S_IDLE;
         err_q     <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         err_q     <= err_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end
endmodule

// File: tb/tb_chunk_fifo.sv
// Directed bench for chunk_fifo: reset, FWFT latency, packets, full, errors, wrap, mid-packet reset.
module tb_chunk_fifo;
   localparam int DEPTH = 8;
   localparam int DW    = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        idle;
   logic        err;
   logic [15:0] pkt_cnt;
   int          n_cmp;
   int          n_fail;

   chunk_fifo_if #(.DW(DW)) bus ();

   chunk_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .idle    (idle),
      .err     (err),
      .pkt_cnt (pkt_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input logic [31:0] t);
      return {8{t}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic [5:0] n, input logic [31:0] t);
      bus.val  = v;
      bus.sop  = s;
      bus.eop  = e;
      bus.vbc  = n;
      bus.data = pat(t);
   endtask

   task automatic no_in();
      drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
   endtask

   task automatic do_reset();
      no_in();
      bus.o_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      no_in();
      bus.o_ready = 1'b0;
      tick();
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL rst_during_oval got=%b exp=0", bus.o_val); end
      n_cmp++; if (bus.o_data !== '0) begin n_fail++; $display("FAIL rst_during_odata got=%h exp=0", bus.o_data); end
      n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
      reset = 1'b0;
      tick();
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%b exp=1", idle); end
      n_cmp++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_pktcnt got=%0d exp=0", pkt_cnt); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
      n_cmp++; if ({bus.o_sop, bus.o_eop, bus.o_vbc} !== 8'h00) begin n_fail++; $display("FAIL rst_ofields got=%b%b%h exp=0", bus.o_sop, bus.o_eop, bus.o_vbc); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      bus.o_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h10 + i);
         tick();
         $display("single wr tag=%h", 32'h10 + i);
         n_cmp++; if (bus.o_val !== 1'b1) begin n_fail++; $display("FAIL single_oval[%0d] got=%b exp=1", i, bus.o_val); end
         n_cmp++; if (bus.o_data !== pat(32'h10 + i)) begin n_fail++; $display("FAIL single_data[%0d] got=%h exp=%h", i, bus.o_data[31:0], 32'h10 + i); end
         n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err[%0d] got=%b exp=0", i, err); end
      end
      no_in();
      tick();
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", bus.o_val); end
      n_cmp++; if (pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL single_pktcnt got=%0d exp=5", pkt_cnt); end
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got=%b exp=1", idle); end
   endtask

   task automatic test_multi();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, i == 0, i == 4, (i == 4) ? 6'd31 : 6'd32, 32'h20 + i);
         tick();
         n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL multi_err[%0d] got=%b exp=0", i, err); end
      end
      no_in();
      n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL multi_ready got=%b exp=1", bus.ready); end
      n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL multi_idle_busy got=%b exp=0", idle); end
      tick();
      n_cmp++; if (bus.o_data !== pat(32'h20)) begin n_fail++; $display("FAIL multi_hold got=%h exp=%h", bus.o_data[31:0], 32'h20); end
      bus.o_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         $display("multi rd tag=%h vbc=%0d sop=%b eop=%b", bus.o_data[31:0], bus.o_vbc, bus.o_sop, bus.o_eop);
         n_cmp++; if (bus.o_data !== pat(32'h20 + i)) begin n_fail++; $display("FAIL multi_data[%0d] got=%h exp=%h", i, bus.o_data[31:0], 32'h20 + i); end
         n_cmp++; if (bus.o_vbc !== ((i == 4) ? 6'd31 : 6'd32)) begin n_fail++; $display("FAIL multi_vbc[%0d] got=%0d", i, bus.o_vbc); end
         n_cmp++; if ({bus.o_sop, bus.o_eop} !== {i == 0, i == 4}) begin n_fail++; $display("FAIL multi_frame[%0d] got=%b%b", i, bus.o_sop, bus.o_eop); end
         tick();
      end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL multi_empty got=%b exp=0", bus.o_val); end
      n_cmp++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL multi_pktcnt got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_fill[%0d] got=%b exp=1", i, bus.ready); end
         drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h30 + i);
         tick();
      end
      n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready0 got=%b exp=0", bus.ready); end
      drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h38);
      tick();
      n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL full_held got=%b exp=0", bus.ready); end
      n_cmp++; if (bus.o_data !== pat(32'h30)) begin n_fail++; $display("FAIL full_head got=%h exp=%h", bus.o_data[31:0], 32'h30); end
      bus.o_ready = 1'b1;
      tick();
      n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL full_freed got=%b exp=1", bus.ready); end
      n_cmp++; if (bus.o_data !== pat(32'h31)) begin n_fail++; $display("FAIL full_head2 got=%h exp=%h", bus.o_data[31:0], 32'h31); end
      bus.o_ready = 1'b0;
      tick();
      n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL full_refill got=%b exp=0", bus.ready); end
      no_in();
      bus.o_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         $display("full rd tag=%h", bus.o_data[31:0]);
         n_cmp++; if (bus.o_data !== pat(32'h31 + i)) begin n_fail++; $display("FAIL full_data[%0d] got=%h exp=%h", i, bus.o_data[31:0], 32'h31 + i); end
         tick();
      end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%b exp=0", bus.o_val); end
      n_cmp++; if (pkt_cnt !== 16'd9) begin n_fail++; $display("FAIL full_pktcnt got=%0d exp=9", pkt_cnt); end
   endtask

   task automatic test_errors();
      logic       es [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      logic       ee [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [5:0] ev [4] = '{6'd32, 6'd0, 6'd33, 6'd20};
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 6'd32, 32'h40);
      tick();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_nosop got=%b exp=1", err); end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL err_nosop_dropped got=%b exp=0", bus.o_val); end
      no_in();
      tick();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_nosop_pulse got=%b exp=0", err); end
      drive(1'b1, 1'b1, 1'b0, 6'd32, 32'h41);
      tick();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_goodstart got=%b exp=0", err); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, es[i], ee[i], ev[i], 32'h60 + i);
         tick();
         $display("err wr sop=%b eop=%b vbc=%0d err=%b", es[i], ee[i], ev[i], err);
         n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_case[%0d] got=%b exp=1", i, err); end
         no_in();
         tick();
         n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse[%0d] got=%b exp=0", i, err); end
         n_cmp++; if (bus.o_data !== pat(32'h41)) begin n_fail++; $display("FAIL err_head[%0d] got=%h exp=%h", i, bus.o_data[31:0], 32'h41); end
      end
      drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h42);
      tick();
      no_in();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_recover got=%b exp=0", err); end
      bus.o_ready = 1'b1;
      n_cmp++; if ({bus.o_data, bus.o_eop} !== {pat(32'h41), 1'b0}) begin n_fail++; $display("FAIL err_drain0 got=%h eop=%b", bus.o_data[31:0], bus.o_eop); end
      tick();
      n_cmp++; if ({bus.o_data, bus.o_eop} !== {pat(32'h42), 1'b1}) begin n_fail++; $display("FAIL err_drain1 got=%h eop=%b", bus.o_data[31:0], bus.o_eop); end
      tick();
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL err_count got=%b exp=0", bus.o_val); end
      n_cmp++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL err_pktcnt got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_wrap();
      logic [31:0] q [$];
      int sent = 0;
      int got = 0;
      do_reset();
      for (int c = 0; c < 300 && (sent < 20 || q.size() != 0); c++) begin
         bus.o_ready = (c % 2 == 0);
         if (sent < 20) drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h100 + sent);
         else no_in();
         if (bus.val && bus.ready) begin
            q.push_back(32'h100 + sent);
            sent++;
         end
         if (bus.o_val && bus.o_ready) begin
            $display("wrap rd tag=%h", bus.o_data[31:0]);
            n_cmp++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL wrap_extra got=%h exp=none", bus.o_data[31:0]);
            end else begin
               if (bus.o_data !== pat(q[0])) begin n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", got, bus.o_data[31:0], q[0]); end
               void'(q.pop_front());
            end
            got++;
         end
         tick();
      end
      no_in();
      n_cmp++; if (got !== 20) begin n_fail++; $display("FAIL wrap_got got=%0d exp=20", got); end
      n_cmp++; if (pkt_cnt !== 16'd20) begin n_fail++; $display("FAIL wrap_pktcnt got=%0d exp=20", pkt_cnt); end
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wrap_idle got=%b exp=1", idle); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 6'd32, 32'h50);
      tick();
      drive(1'b1, 1'b0, 1'b0, 6'd32, 32'h51);
      tick();
      drive(1'b1, 1'b0, 1'b0, 6'd32, 32'h52);
      tick();
      no_in();
      n_cmp++; if ({bus.o_val, idle} !== 2'b10) begin n_fail++; $display("FAIL midrst_pre got=%b%b exp=10", bus.o_val, idle); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (bus.o_val !== 1'b0) begin n_fail++; $display("FAIL midrst_oval got=%b exp=0", bus.o_val); end
      n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.ready); end
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got=%b exp=1", idle); end
      n_cmp++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_pktcnt got=%0d exp=0", pkt_cnt); end
      n_cmp++; if (bus.o_data !== '0) begin n_fail++; $display("FAIL midrst_odata got=%h exp=0", bus.o_data[31:0]); end
      drive(1'b1, 1'b1, 1'b1, 6'd32, 32'h53);
      tick();
      no_in();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got=%b exp=0", err); end
      n_cmp++; if (bus.o_data !== pat(32'h53)) begin n_fail++; $display("FAIL midrst_newpkt got=%h exp=%h", bus.o_data[31:0], 32'h53); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_multi();
      test_full();
      test_errors();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
